fixed_broadcast_fork: RTL and testbench

//  Fans one fixed-point stream out to OUT_SIZE consumers (the distribution counterpart of the adder tree's reduction).

---
 rtl/fixed_broadcast_pkg.sv | 26 ++
 rtl/fixed_broadcast_lane.sv | 36 +++
 rtl/skid_buffer.sv | 51 +++++
 rtl/fixed_broadcast_fork.sv | 85 ++++++++
 tb/tb_fixed_broadcast_fork.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/fixed_broadcast_pkg.sv
// Shared helpers for the fixed-point broadcast fork: sign extension and fork completion test.
package fixed_broadcast_pkg;

    localparam int unsigned MaxWidth = 64;
    localparam int unsigned MaxLanes = 64;

    // Replicates bit in_width-1 of value into every higher bit position.
    function automatic logic [MaxWidth-1:0] sext(input logic [MaxWidth-1:0] value,
                                                 input int unsigned in_width);
        logic [MaxWidth-1:0] result;
        result = value;
        for (int unsigned i = 0; i < MaxWidth; i++) begin
            if (i >= in_width) begin
                result[i] = value[in_width-1];
            end
        end
        return result;
    endfunction

    // True when no outstanding lane is left waiting after this cycle.
    function automatic logic all_done(input logic [MaxLanes-1:0] pending,
                                      input logic [MaxLanes-1:0] ready);
        return (pending & ~ready) == '0;
    endfunction

endpackage

// File: rtl/fixed_broadcast_lane.sv
// One fork lane: holds the pending flag for the current beat until this lane's handshake.
module fixed_broadcast_lane (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic ready,
    output logic valid,
    output logic done
);

    logic pending_q;
    logic pending_d;

    assign done = pending_q && ready;

    // A new beat wins over the completion of the old one.
    always_comb begin
        pending_d = pending_q;
        if (set) begin
            pending_d = 1'b1;
        end else if (done) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign valid = pending_q;

endmodule

// File: rtl/skid_buffer.sv
// Two-entry skid buffer: registered output stage plus one overflow entry, registered in-ready.
module skid_buffer #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready
);

    logic [DATA_WIDTH-1:0] out_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  out_valid_q;
    logic                  skid_valid_q;
    logic                  in_fire;

    assign in_fire = data_in_valid && !skid_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (data_out_ready || !out_valid_q) begin
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else begin
                out_valid_q <= in_fire;
                if (in_fire) begin
                    out_q <= data_in;
                end
            end
        end else if (in_fire) begin
            // Output stalled: park the beat accepted on the previous ready.
            skid_q       <= data_in;
            skid_valid_q <= 1'b1;
        end
    end

    assign data_in_ready  = !skid_valid_q;
    assign data_out       = out_q;
    assign data_out_valid = out_valid_q;

endmodule

// File: rtl/fixed_broadcast_fork.sv
// Eager broadcast fork of a signed stream to OUT_SIZE lanes with sign extension.
// Build option FIXED_BROADCAST_FORK_SKID_EN inserts a skid_buffer ahead of the fork core.
module fixed_broadcast_fork
    import fixed_broadcast_pkg::*;
#(
    parameter int unsigned OUT_SIZE  = 4,
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH = IN_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  data_in,
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    output logic [OUT_WIDTH-1:0] data_out [OUT_SIZE-1:0],
    output logic [OUT_SIZE-1:0]  data_out_valid,
    input  logic [OUT_SIZE-1:0]  data_out_ready
);

    if (OUT_WIDTH < IN_WIDTH) begin : g_width_err
        $error("fixed_broadcast_fork: OUT_WIDTH must be >= IN_WIDTH");
    end
    if (OUT_WIDTH > MaxWidth || OUT_SIZE > MaxLanes || OUT_SIZE < 1) begin : g_range_err
        $error("fixed_broadcast_fork: OUT_WIDTH or OUT_SIZE out of supported range");
    end

    logic [IN_WIDTH-1:0]  core_data;
    logic                 core_valid;
    logic                 core_ready;
    logic [IN_WIDTH-1:0]  hold_q;
    logic [OUT_SIZE-1:0]  pending;
    logic [OUT_SIZE-1:0]  lane_done;
    logic [OUT_WIDTH-1:0] data_ext;
    logic                 last_go;
    logic                 accept;

`ifdef FIXED_BROADCAST_FORK_SKID_EN
    skid_buffer #(
        .DATA_WIDTH(IN_WIDTH)
    ) u_skid (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (core_data),
        .data_out_valid (core_valid),
        .data_out_ready (core_ready)
    );
`else
    assign core_data     = data_in;
    assign core_valid    = data_in_valid;
    assign data_in_ready = core_ready;
`endif

    // pending & ~done equals pending & ~ready, so lane_done stands in for the ready mask.
    assign last_go    = all_done(MaxLanes'(pending), MaxLanes'(lane_done));
    assign core_ready = last_go;
    assign accept     = core_valid && last_go;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else if (accept) begin
            hold_q <= core_data;
        end
    end

    assign data_ext = OUT_WIDTH'(sext(MaxWidth'(hold_q), IN_WIDTH));

    for (genvar j = 0; j < OUT_SIZE; j++) begin : g_lane
        fixed_broadcast_lane u_lane (
            .clk   (clk),
            .rst   (rst),
            .set   (accept),
            .ready (data_out_ready[j]),
            .valid (pending[j]),
            .done  (lane_done[j])
        );
        assign data_out[j] = data_ext;
    end

    assign data_out_valid = pending;

endmodule

// File: tb/tb_fixed_broadcast_fork.sv
// Randomised and directed bench for fixed_broadcast_fork against a per-lane history model.
module tb_fixed_broadcast_fork;

    localparam int N  = 4;
    localparam int IW = 8;
    localparam int OW = 12;
`ifdef FIXED_BROADCAST_FORK_SKID_EN
    localparam int LAT   = 2;
    localparam bit EXACT = 1'b0;
`else
    localparam int LAT   = 1;
    localparam bit EXACT = 1'b1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] data_in;
    logic          data_in_valid;
    logic          data_in_ready;
    logic [OW-1:0] data_out [N-1:0];
    logic [N-1:0]  data_out_valid;
    logic [N-1:0]  data_out_ready;

    always #5 clk = ~clk;

    fixed_broadcast_fork #(
        .OUT_SIZE  (N),
        .IN_WIDTH  (IW),
        .OUT_WIDTH (OW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [OW-1:0] ext(input logic [IW-1:0] x);
        return OW'($signed(x));
    endfunction

    // Model: every accepted beat is appended to hist; lane j has consumed rd_idx[j] of them.
    logic [IW-1:0] hist [$];
    int            rd_idx [N];
    logic [N-1:0]  owed;
    logic [IW-1:0] held;
    logic [N-1:0]  prev_hold;
    logic [OW-1:0] prev_data [N];
    bit            after_rst;
    bit            must_rdy;
    bit            lat_arm;
    bit            lat_wait;
    int            t_in;
    int            cyc;

    task automatic cycle(input logic r, input logic v, input logic [IW-1:0] d,
                         input logic [N-1:0] rdy);
        logic fire_in;
        rst            = r;
        data_in_valid  = v;
        data_in        = d;
        data_out_ready = rdy;
        @(negedge clk);
        if (r) begin
            owed      = '0;
            held      = '0;
            prev_hold = '0;
            hist.delete();
            for (int j = 0; j < N; j++) rd_idx[j] = 0;
            after_rst = 1'b1;
        end else begin
            if (after_rst) begin
                check("rst_valid", 32'(data_out_valid), 32'd0);
                for (int j = 0; j < N; j++) check("rst_data", 32'(data_out[j]), 32'd0);
                after_rst = 1'b0;
            end
            if (EXACT) begin
                check("in_ready", 32'(data_in_ready), 32'((owed & ~rdy) == '0));
                check("out_valid", 32'(data_out_valid), 32'(owed));
                for (int j = 0; j < N; j++) check("out_data", 32'(data_out[j]), 32'(ext(held)));
            end
            if (must_rdy) check("in_ready_hi", 32'(data_in_ready), 32'd1);
            for (int j = 0; j < N; j++) begin
                if (prev_hold[j]) begin
                    check("hold_valid", 32'(data_out_valid[j]), 32'd1);
                    check("hold_data", 32'(data_out[j]), 32'(prev_data[j]));
                end
                if (data_out_valid[j] && rdy[j]) begin
                    check("lane_has_beat", 32'(rd_idx[j] < hist.size()), 32'd1);
                    if (rd_idx[j] < hist.size()) begin
                        check("lane_seq", 32'(data_out[j]), 32'(ext(hist[rd_idx[j]])));
                        rd_idx[j]++;
                    end
                end
                prev_hold[j] = data_out_valid[j] && !rdy[j];
                prev_data[j] = data_out[j];
            end
            if (lat_wait && ((|data_out_valid) || (cyc - t_in > 6))) begin
                check("latency", 32'(cyc - t_in), 32'(LAT));
                lat_wait = 1'b0;
            end
            fire_in = v && data_in_ready;
            if (lat_arm && fire_in) begin
                t_in     = cyc;
                lat_arm  = 1'b0;
                lat_wait = 1'b1;
            end
            owed = owed & ~rdy;
            if (fire_in) begin
                owed = '1;
                held = d;
                hist.push_back(d);
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        owed = '0; held = '0; prev_hold = '0; cyc = 0; t_in = 0;
        after_rst = 1'b0; must_rdy = 1'b0; lat_arm = 1'b0; lat_wait = 1'b0;
        for (int j = 0; j < N; j++) rd_idx[j] = 0;
        rst = 1'b1; data_in = '0; data_in_valid = 1'b0; data_out_ready = '1;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 8'h00, 4'hF);
        cycle(1'b1, 1'b0, 8'h00, 4'hF);

        // Full-rate stream with all lanes ready, including sign-extension extremes.
        lat_arm  = 1'b1;
        must_rdy = 1'b1;
        cycle(1'b0, 1'b1, 8'h7F, 4'hF);
        cycle(1'b0, 1'b1, 8'h80, 4'hF);
        cycle(1'b0, 1'b1, 8'h01, 4'hF);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'h00, 4'hF);
        must_rdy = 1'b0;

        // Lane 2 stalls for five cycles while a second beat waits.
        cycle(1'b0, 1'b1, 8'hA5, 4'hF);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'h3C, 4'b1011);
        cycle(1'b0, 1'b1, 8'h3C, 4'hF);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'h00, 4'hF);

        // Staggered readiness, one lane per cycle.
        cycle(1'b0, 1'b1, 8'h55, 4'hF);
        cycle(1'b0, 1'b1, 8'hC3, 4'b0001);
        cycle(1'b0, 1'b1, 8'hC3, 4'b0010);
        cycle(1'b0, 1'b1, 8'hC3, 4'b0100);
        cycle(1'b0, 1'b1, 8'hC3, 4'b1000);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 8'h00, 4'hF);

        // Reset while lanes 1 and 2 still owe a beat.
        cycle(1'b0, 1'b1, 8'h12, 4'hF);
        cycle(1'b0, 1'b1, 8'h34, 4'b1001);
        cycle(1'b0, 1'b1, 8'h56, 4'b0000);
        cycle(1'b1, 1'b1, 8'h56, 4'b0000);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'h00, 4'hF);

        // Random traffic.
        for (int i = 0; i < 10000; i++) begin
            logic [N-1:0] rdy;
            for (int j = 0; j < N; j++) rdy[j] = ($urandom_range(0, 3) != 0);
            cycle(1'b0, ($urandom_range(0, 2) != 0), IW'($urandom), rdy);
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 8'h00, 4'hF);
        for (int j = 0; j < N; j++) check("drain", 32'(rd_idx[j]), 32'(hist.size()));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
